// File: rtl/fractran_program_store_pkg.sv
// Shared definitions for the FRACTRAN program store: FSM states, default sizes
// and the value presented when no fraction is selected.
package fractran_program_store_pkg;

    localparam int DEPTH_DEF  = 64;
    localparam int STEP_W_DEF = 16;

    // Returned on fraction_o when the index is past the program or the engine is idle.
    localparam logic [7:0] FRAC_TERM = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fractran_prog_mem.sv
// Fraction storage: DEPTH x 8 array with one write port and one registered
// read port, shaped so it maps onto a block RAM. Contents are never reset.
module fractran_prog_mem #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem_reg [DEPTH];

    // Write port plus registered read; read-during-write never occurs in practice
    // because writes happen only while loading.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        rd_data <= mem_reg[rd_addr];
    end

endmodule

// File: rtl/fractran_program_store.sv
// FRACTRAN program store: accepts a host-loaded program (initial accumulator
// followed by fractions), serves fractions to the execution engine, captures
// accumulator write-backs and bounds the run length with a step counter.
module fractran_program_store
    import fractran_program_store_pkg::*;
#(
    parameter int  DEPTH  = DEPTH_DEF,
    parameter int  STEP_W = STEP_W_DEF,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [7:0]       load_data,
    input  logic             load_last,
    output logic             load_ready,
    input  logic             start,
    input  logic [IDX_W-1:0] count_i,
    input  logic             we_i,
    input  logic [7:0]       degree_i,
    input  logic             halt_i,
    output logic [7:0]       fraction_o,
    output logic [7:0]       accumulator_o,
    output logic [7:0]       result_o,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W:0]   prog_len
);

    localparam logic [IDX_W:0]    LEN_MAX   = (IDX_W + 1)'(DEPTH);
    localparam logic [STEP_W-1:0] STEP_MAX  = '1;
    localparam logic [STEP_W-1:0] STEP_LAST = {{(STEP_W-1){1'b1}}, 1'b0};

    state_e            state_reg, state_next;
    logic [IDX_W:0]    prog_len_reg;
    logic [7:0]        init_acc_reg;
    logic [7:0]        acc_reg;
    logic [7:0]        result_reg;
    logic [STEP_W-1:0] step_reg;
    logic              err_ovf_reg;
    logic              err_to_reg;
    logic              sel_reg;
    logic [7:0]        rd_data;

    logic has_prog;
    logic prog_full;
    logic load_first;
    logic load_beat;
    logic start_ok;
    logic run_we;
    logic step_at_limit;

    assign has_prog      = (prog_len_reg != '0);
    assign prog_full     = (prog_len_reg == LEN_MAX);
    // The beat that leaves IDLE carries the initial accumulator, not a fraction.
    assign load_first    = (state_reg == ST_IDLE) && load_valid;
    assign load_beat     = (state_reg == ST_LOAD) && load_valid;
    // A load beat in IDLE wins over a coincident start.
    assign start_ok      = start && has_prog &&
                           (((state_reg == ST_IDLE) && !load_valid) || (state_reg == ST_DONE));
    assign run_we        = (state_reg == ST_RUN) && we_i;
    // This write-back brings the counter to its all-ones value.
    assign step_at_limit = (step_reg == STEP_LAST);

    // Next-state logic for the load / run / done sequencing.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load_valid) begin
                    state_next = load_last ? ST_IDLE : ST_LOAD;
                end else if (start_ok) begin
                    state_next = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_valid && load_last) begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (halt_i || (we_i && step_at_limit)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start_ok) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register and the fraction-select flag that qualifies the RAM read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= (state_next == ST_RUN) && ({1'b0, count_i} < prog_len_reg);
        end
    end

    // Program length, initial accumulator and overflow error from the host side.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prog_len_reg <= '0;
            init_acc_reg <= '0;
            err_ovf_reg  <= 1'b0;
        end else if (load_first) begin
            init_acc_reg <= load_data;
            prog_len_reg <= '0;
        end else if (load_beat) begin
            if (prog_full) begin
                err_ovf_reg <= 1'b1;
            end else begin
                prog_len_reg <= prog_len_reg + 1'b1;
            end
        end
    end

    // Engine-side capture: accumulator, result, step counter and timeout error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg    <= '0;
            result_reg <= '0;
            step_reg   <= '0;
            err_to_reg <= 1'b0;
        end else if (start_ok) begin
            acc_reg    <= init_acc_reg;
            result_reg <= '0;
            step_reg   <= '0;
            err_to_reg <= 1'b0;
        end else if (run_we) begin
            acc_reg    <= degree_i;
            result_reg <= degree_i;
            if (step_at_limit) begin
                step_reg   <= STEP_MAX;
                err_to_reg <= 1'b1;
            end else begin
                step_reg <= step_reg + 1'b1;
            end
        end
    end

    fractran_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (load_beat && !prog_full),
        .wr_addr (prog_len_reg[IDX_W-1:0]),
        .wr_data (load_data),
        .rd_addr (count_i),
        .rd_data (rd_data)
    );

    assign load_ready    = (state_reg == ST_LOAD);
    assign busy          = (state_reg == ST_RUN);
    assign done          = (state_reg == ST_DONE);
    assign err           = err_ovf_reg | err_to_reg;
    assign prog_len      = prog_len_reg;
    assign accumulator_o = acc_reg;
    assign result_o      = result_reg;
    assign fraction_o    = sel_reg ? rd_data : FRAC_TERM;

endmodule

// File: tb/tb_fractran_program_store.sv
// Bench for fractran_program_store: directed scenarios followed by random
// traffic. Each stimulus cycle pushes the reference model's expected outputs
// into a scoreboard queue; a monitor pops and compares after every clock edge.
module tb_fractran_program_store;

    localparam int DEPTH      = 64;
    localparam int STEP_W     = 4;
    localparam int STEP_LIMIT = (1 << STEP_W) - 1;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       start;
    logic [5:0] count_i;
    logic       we_i;
    logic [7:0] degree_i;
    logic       halt_i;
    logic [7:0] fraction_o;
    logic [7:0] accumulator_o;
    logic [7:0] result_o;
    logic       busy;
    logic       done;
    logic       err;
    logic [6:0] prog_len;

    fractran_program_store #(
        .DEPTH  (DEPTH),
        .STEP_W (STEP_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .start         (start),
        .count_i       (count_i),
        .we_i          (we_i),
        .degree_i      (degree_i),
        .halt_i        (halt_i),
        .fraction_o    (fraction_o),
        .accumulator_o (accumulator_o),
        .result_o      (result_o),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .prog_len      (prog_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       lr;
        logic       busy;
        logic       done;
        logic       err;
        int         len;
        logic [7:0] frac;
        logic [7:0] acc;
        logic [7:0] res;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: the program as a queue of bytes plus a run mode.
    int         m_mode  = M_IDLE;
    logic [7:0] prog_q[$];
    logic [7:0] m_init  = 8'h00;
    logic [7:0] m_acc   = 8'h00;
    logic [7:0] m_res   = 8'h00;
    int         m_steps = 0;
    bit         m_ovf   = 1'b0;
    bit         m_to    = 1'b0;
    logic [7:0] m_frac  = 8'h00;

    task automatic chk(input string what, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", what, act, req);
        end
    endtask

    task automatic model_begin_run();
        m_mode  = M_RUN;
        m_acc   = m_init;
        m_res   = 8'h00;
        m_steps = 0;
        m_to    = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        if (!rst_n) begin
            m_mode = M_IDLE;
            prog_q.delete();
            m_init = 8'h00; m_acc = 8'h00; m_res = 8'h00;
            m_steps = 0; m_ovf = 1'b0; m_to = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (load_valid) begin
                        m_init = load_data;
                        prog_q.delete();
                        m_mode = load_last ? M_IDLE : M_LOAD;
                    end else if (start && prog_q.size() > 0) begin
                        model_begin_run();
                    end
                end
                M_LOAD: begin
                    if (load_valid) begin
                        if (prog_q.size() < DEPTH) prog_q.push_back(load_data);
                        else m_ovf = 1'b1;
                        if (load_last) m_mode = M_IDLE;
                    end
                end
                M_RUN: begin
                    if (we_i) begin
                        m_acc = degree_i;
                        m_res = degree_i;
                        m_steps++;
                        if (m_steps >= STEP_LIMIT) begin
                            m_to   = 1'b1;
                            m_mode = M_DONE;
                        end
                    end
                    if (halt_i) m_mode = M_DONE;
                end
                default: begin
                    if (start && prog_q.size() > 0) model_begin_run();
                end
            endcase
        end
        if (m_mode == M_RUN && int'(count_i) < prog_q.size()) m_frac = prog_q[count_i];
        else m_frac = 8'h00;
    endtask

    // One stimulus cycle: inputs are already driven; record expectation, clock it.
    task automatic cyc(input string nm);
        exp_t e;
        model_step();
        e.lr   = (m_mode == M_LOAD);
        e.busy = (m_mode == M_RUN);
        e.done = (m_mode == M_DONE);
        e.err  = m_ovf | m_to;
        e.len  = prog_q.size();
        e.frac = m_frac;
        e.acc  = m_acc;
        e.res  = m_res;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        start = 1'b0; we_i = 1'b0; degree_i = 8'h00; halt_i = 1'b0;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation after each edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                $display("%0t %-10s lr=%0b busy=%0b done=%0b err=%0b len=%0d frac=%h acc=%h res=%h",
                         $time, nm, load_ready, busy, done, err, prog_len, fraction_o, accumulator_o, result_o);
                chk({nm, ".load_ready"}, 32'(load_ready), 32'(e.lr));
                chk({nm, ".busy"},       32'(busy),       32'(e.busy));
                chk({nm, ".done"},       32'(done),       32'(e.done));
                chk({nm, ".err"},        32'(err),        32'(e.err));
                chk({nm, ".prog_len"},   32'(prog_len),   32'(e.len));
                chk({nm, ".fraction"},   32'(fraction_o), 32'(e.frac));
                chk({nm, ".acc"},        32'(accumulator_o), 32'(e.acc));
                chk({nm, ".result"},     32'(result_o),   32'(e.res));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] frac64;
        rst_n = 1'b0;
        count_i = 6'd0;
        clear_inputs();
        @(negedge clk);
        cyc("reset");
        cyc("reset");
        chk("reset.prog_len", 32'(prog_len), 32'd0);
        chk("reset.acc", 32'(accumulator_o), 32'd0);
        rst_n = 1'b1;
        cyc("idle");

        // Load 05 (accumulator), 21, 43 (last).
        load_valid = 1'b1; load_data = 8'h05; cyc("ld_acc");
        load_data = 8'h21; cyc("ld_f0");
        load_data = 8'h43; load_last = 1'b1; cyc("ld_f1");
        clear_inputs(); cyc("idle");
        chk("load.prog_len", 32'(prog_len), 32'd2);

        start = 1'b1; count_i = 6'd1; cyc("start");
        start = 1'b0; cyc("rd1");
        chk("read.idx1", 32'(fraction_o), 32'h43);
        count_i = 6'd2; cyc("rd2");
        chk("read.idx2", 32'(fraction_o), 32'h00);
        count_i = 6'd0; cyc("rd0");
        chk("read.idx0", 32'(fraction_o), 32'h21);

        // Write-back then halt two cycles later.
        we_i = 1'b1; degree_i = 8'h3C; cyc("we3c");
        clear_inputs(); cyc("gap");
        halt_i = 1'b1; cyc("halt");
        clear_inputs();
        chk("halt.acc", 32'(accumulator_o), 32'h3C);
        chk("halt.result", 32'(result_o), 32'h3C);
        chk("halt.done", 32'(done), 32'd1);
        chk("halt.busy", 32'(busy), 32'd0);

        // Re-run, then simultaneous write-back and halt.
        start = 1'b1; cyc("rerun");
        clear_inputs();
        chk("rerun.acc", 32'(accumulator_o), 32'h05);
        we_i = 1'b1; halt_i = 1'b1; degree_i = 8'h7F; cyc("we_halt");
        clear_inputs();
        chk("we_halt.result", 32'(result_o), 32'h7F);
        chk("we_halt.done", 32'(done), 32'd1);

        // Step timeout after 15 write-backs.
        start = 1'b1; cyc("start_to");
        clear_inputs();
        for (int i = 0; i < STEP_LIMIT; i++) begin
            we_i = 1'b1; degree_i = 8'($urandom); cyc("we_to");
        end
        clear_inputs();
        chk("timeout.done", 32'(done), 32'd1);
        chk("timeout.err", 32'(err), 32'd1);
        start = 1'b1; cyc("restart");
        clear_inputs();
        chk("restart.busy", 32'(busy), 32'd1);
        chk("restart.err", 32'(err), 32'd0);
        chk("restart.acc", 32'(accumulator_o), 32'h05);

        // Reset in the middle of a run.
        we_i = 1'b1; degree_i = 8'h11; cyc("we11");
        clear_inputs();
        rst_n = 1'b0; cyc("rst_run");
        rst_n = 1'b1;
        chk("rst_run.busy", 32'(busy), 32'd0);
        chk("rst_run.result", 32'(result_o), 32'd0);
        start = 1'b1; cyc("start_empty");
        clear_inputs();
        chk("start_empty.busy", 32'(busy), 32'd0);

        // Overflow: accumulator plus 66 fraction beats.
        frac64 = 8'h00;
        load_valid = 1'b1; load_data = 8'h09; cyc("ov_acc");
        for (int i = 0; i < 66; i++) begin
            load_data = 8'($urandom);
            if (i == 63) frac64 = load_data;
            load_last = (i == 65);
            cyc("ov_beat");
        end
        clear_inputs();
        chk("overflow.prog_len", 32'(prog_len), 32'd64);
        chk("overflow.err", 32'(err), 32'd1);
        start = 1'b1; count_i = 6'd63; cyc("ov_start");
        clear_inputs(); cyc("ov_rd63");
        chk("overflow.mem63", 32'(fraction_o), 32'(frac64));

        // Random traffic against the model.
        rst_n = 1'b0; cyc("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 800; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            load_valid = ($urandom_range(0, 2) == 0);
            load_data  = 8'($urandom);
            load_last  = ($urandom_range(0, 7) == 0);
            start      = !load_valid && ($urandom_range(0, 7) == 0);
            we_i       = ($urandom_range(0, 1) == 0);
            degree_i   = 8'($urandom);
            halt_i     = ($urandom_range(0, 15) == 0);
            count_i    = 6'($urandom_range(0, 15));
            cyc("rand");
        end
        rst_n = 1'b1;
        clear_inputs();
        cyc("final");

        chk("scoreboard.drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
